// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 encodings, FSM state type, default operand width and the
// operand-signedness decode used by the datapath.
package muldiv_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // rs1 is interpreted as two's complement for these operations
    function automatic logic rs1_is_signed(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
               (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    // rs2 is interpreted as two's complement for these operations;
    // MULHSU deliberately treats rs2 as unsigned
    function automatic logic rs2_is_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    // Unsigned variants, kept for readability of callers
    function automatic logic is_unsigned_op(input logic [2:0] f3);
        return (f3 == F3_MULHU) || (f3 == F3_DIVU) || (f3 == F3_REMU);
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Radix-2 shift-add multiplier / restoring divider sharing one
// 2*XLEN+1 accumulator. Operands are converted to magnitudes on load,
// one bit is processed per step, and the sign correction is applied
// combinationally so the result is ready while the FSM sits in FIX.
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            load,
    input  logic            step,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    output logic [XLEN-1:0] fix_result
);

    localparam int AW = 2 * XLEN + 1;
    localparam logic [XLEN-1:0]   ONE_W  = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [2*XLEN-1:0] ONE_2W = {{(2*XLEN-1){1'b0}}, 1'b1};

    logic signed [XLEN-1:0] a_s;
    logic signed [XLEN-1:0] b_s;
    logic                   a_neg;
    logic                   b_neg;
    logic [XLEN-1:0]        a_mag;
    logic [XLEN-1:0]        b_mag;

    // acc[2X:X] is the partial product / remainder, acc[X-1:0] the
    // multiplier / dividend-quotient; the top bit keeps the adder carry
    logic [AW-1:0]          acc;
    logic [XLEN-1:0]        opb;
    logic [2:0]             f3_r;
    logic                   neg_res_r;
    logic                   neg_a_r;

    logic [XLEN:0]          add_sum;
    logic [XLEN:0]          trial;
    logic [AW-1:0]          mul_nxt;
    logic [AW-1:0]          shl;
    logic [AW-1:0]          div_nxt;
    logic [2*XLEN-1:0]      prod_fix;
    logic [XLEN-1:0]        quo_fix;
    logic [XLEN-1:0]        rem_fix;

    function automatic logic [XLEN-1:0] neg_w(input logic [XLEN-1:0] v);
        return ~v + ONE_W;
    endfunction

    function automatic logic [2*XLEN-1:0] neg_2w(input logic [2*XLEN-1:0] v);
        return ~v + ONE_2W;
    endfunction

    // Decode operand signs and form magnitudes from the raw register values
    always_comb begin
        a_s   = signed'(rs1_val);
        b_s   = signed'(rs2_val);
        a_neg = rs1_is_signed(funct3) && (a_s < 0);
        b_neg = rs2_is_signed(funct3) && (b_s < 0);
        a_mag = a_neg ? neg_w(rs1_val) : rs1_val;
        b_mag = b_neg ? neg_w(rs2_val) : rs2_val;
    end

    // Next accumulator value for one multiply or one divide iteration
    always_comb begin
        add_sum = acc[AW-1:XLEN] + (acc[0] ? {1'b0, opb} : '0);
        mul_nxt = {1'b0, add_sum, acc[XLEN-1:1]};
        shl     = {acc[AW-2:0], 1'b0};
        trial   = shl[AW-1:XLEN] - {1'b0, opb};
        div_nxt = trial[XLEN] ? shl : {trial, shl[XLEN-1:1], 1'b1};
    end

    // Latch magnitudes and sign flags on accept, then iterate while stepping
    always_ff @(posedge clk) begin
        if (load) begin
            acc       <= {{(XLEN+1){1'b0}}, a_mag};
            opb       <= b_mag;
            f3_r      <= funct3;
            neg_res_r <= a_neg ^ b_neg;
            neg_a_r   <= a_neg;
        end else if (step) begin
            acc <= f3_r[2] ? div_nxt : mul_nxt;
        end
    end

    // Sign correction and result selection, consumed during FIX
    always_comb begin
        prod_fix = neg_res_r ? neg_2w(acc[2*XLEN-1:0]) : acc[2*XLEN-1:0];
        quo_fix  = neg_res_r ? neg_w(acc[XLEN-1:0]) : acc[XLEN-1:0];
        rem_fix  = neg_a_r ? neg_w(acc[2*XLEN-1:XLEN]) : acc[2*XLEN-1:XLEN];
        if (f3_r[2]) begin
            fix_result = f3_r[1] ? rem_fix : quo_fix;
        end else begin
            fix_result = (f3_r == F3_MUL) ? prod_fix[XLEN-1:0]
                                          : prod_fix[2*XLEN-1:XLEN];
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Execute-stage RV32M multiply/divide unit. Owns the control FSM,
// iteration counter, divide-by-zero / overflow fast path, the stall
// handshake toward issue and the result/rd output registers.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            start,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    localparam logic [XLEN-1:0] INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [5:0]      LAST_ITER = 6'(XLEN - 1);

    state_t          state;
    state_t          state_nxt;
    logic [5:0]      cnt;
    logic [2:0]      funct3;
    logic            can_accept;
    logic            accept;
    logic            div_zero;
    logic            div_ovf;
    logic            fast;
    logic [XLEN-1:0] fast_val;
    logic [XLEN-1:0] dp_result;
    logic [4:0]      rd_lat;
    logic            dp_load;
    logic            dp_step;

    assign funct3     = op[2:0];
    assign can_accept = (state == ST_IDLE) || (state == ST_DONE);
    assign accept     = start & op[3] & ~flush & can_accept;
    assign busy       = (state == ST_CALC) || (state == ST_FIX);
    assign stall      = (accept & ~fast) | busy;
    assign done       = (state == ST_DONE) & ~flush;
    assign dp_load    = accept & ~fast;
    assign dp_step    = (state == ST_CALC);

    // Detect operand pairs whose result is known without iterating
    always_comb begin
        div_zero = funct3[2] && (rs2_val == '0);
        div_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                   (rs1_val == INT_MIN) && (rs2_val == '1);
        fast     = div_zero | div_ovf;
        fast_val = '0;
        if (div_zero) begin
            fast_val = funct3[1] ? rs1_val : '1;
        end else if (div_ovf) begin
            fast_val = funct3[1] ? '0 : INT_MIN;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state; flush overrides everything
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    state_nxt = fast ? ST_DONE : ST_CALC;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (cnt == LAST_ITER) begin
                    state_nxt = ST_FIX;
                end
            end
            ST_FIX:  state_nxt = ST_DONE;
            default: state_nxt = ST_IDLE;
        endcase
        if (flush) begin
            state_nxt = ST_IDLE;
        end
    end

    // Iteration counter, one count per CALC cycle, wrapping after the last
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt <= '0;
        end else if (accept || flush) begin
            cnt <= '0;
        end else if (state == ST_CALC) begin
            cnt <= (cnt == LAST_ITER) ? '0 : cnt + 6'd1;
        end
    end

    // Destination register travels with the operation until FIX
    always_ff @(posedge clk) begin
        if (accept) begin
            rd_lat <= rd_in;
        end
    end

    // Output registers load on the edge entering DONE and hold otherwise
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            result <= '0;
            rd_out <= '0;
        end else if (accept && fast) begin
            result <= fast_val;
            rd_out <= rd_in;
        end else if ((state == ST_FIX) && !flush) begin
            result <= dp_result;
            rd_out <= rd_lat;
        end
    end

    muldiv_datapath #(
        .XLEN(XLEN)
    ) u_datapath (
        .clk        (clk),
        .load       (dp_load),
        .step       (dp_step),
        .funct3     (funct3),
        .rs1_val    (rs1_val),
        .rs2_val    (rs2_val),
        .fix_result (dp_result)
    );

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, hand-written
// flush / collision / reset / back-to-back sequences, and randomized
// operations compared against a plain-arithmetic RV32M reference model.
module tb_muldiv_unit;

    logic        clk;
    logic        nrst;
    logic        start;
    logic [3:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd_in;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[21];

    muldiv_unit #(.XLEN(32)) dut (
        .clk     (clk),
        .nrst    (nrst),
        .start   (start),
        .op      (op),
        .rs1_val (rs1),
        .rs2_val (rs2),
        .rd_in   (rd_in),
        .flush   (flush),
        .stall   (stall),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .rd_out  (rd_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // RV32M semantics computed directly with 64-bit / 32-bit arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        int     ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        ia = int'(a);
        ib = int'(b);
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(ia / ib);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(ia % ib);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction

    // Issue one op from IDLE or DONE and follow it to its done pulse.
    // Ends in the done cycle with start low. With noise set, random
    // starts are driven while the unit is calculating; they must be ignored.
    task automatic do_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                         input bit noise);
        bit fastp;
        int exp_lat;
        int n;
        int stall_bad;
        fastp = (f3[2] && b == 32'h0) ||
                ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        exp_lat = fastp ? 1 : 34;
        op = {1'b1, f3};
        rs1 = a;
        rs2 = b;
        rd_in = rd;
        start = 1'b1;
        #1;
        chk({name, "_stall_t0"}, 32'(stall), 32'(!fastp));
        tick();
        start = 1'b0;
        n = 1;
        stall_bad = 0;
        while (done !== 1'b1 && n < 60) begin
            if (stall !== 1'b1) stall_bad++;
            if (noise && n <= 32) begin
                start = 1'($urandom);
                op = 4'($urandom);
                rs1 = $urandom();
                rs2 = $urandom();
                rd_in = 5'($urandom);
            end else begin
                start = 1'b0;
            end
            tick();
            n++;
        end
        start = 1'b0;
        chk({name, "_latency"}, 32'(n), 32'(exp_lat));
        chk({name, "_stall_busy"}, 32'(stall_bad), 32'd0);
        chk({name, "_stall_done"}, 32'(stall), 32'd0);
        chk({name, "_result"}, result, exp);
        chk({name, "_rd_out"}, 32'(rd_out), 32'(rd));
    endtask

    initial begin
        int cnt_done;
        logic [2:0]  rf3;
        logic [31:0] ra, rb;
        logic [4:0]  rrd;

        vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
        vecs[1]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[2]  = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
        vecs[6]  = '{3'd5, 32'd100,        32'd7,         32'd14};
        vecs[7]  = '{3'd7, 32'd100,        32'd7,         32'd2};
        vecs[8]  = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF};
        vecs[9]  = '{3'd6, 32'd5,          32'd0,         32'd5};
        vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
        vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0};
        vecs[12] = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000};
        vecs[13] = '{3'd4, 32'h8000_0000,  32'd1,         32'h8000_0000};
        vecs[14] = '{3'd4, 32'hFFFF_FFF9,  32'hFFFF_FFFE, 32'd3};
        vecs[15] = '{3'd0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd1};
        vecs[16] = '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF};
        vecs[17] = '{3'd7, 32'h1234_5678,  32'd0,         32'h1234_5678};
        vecs[18] = '{3'd6, 32'hFFFF_FFF9,  32'hFFFF_FFFE, 32'hFFFF_FFFF};
        vecs[19] = '{3'd3, 32'h8000_0000,  32'd2,         32'd1};
        vecs[20] = '{3'd5, 32'hFFFF_FFFF,  32'd16,        32'h0FFF_FFFF};

        nrst = 1'b0;
        start = 1'b0;
        op = 4'h0;
        rs1 = '0;
        rs2 = '0;
        rd_in = '0;
        flush = 1'b0;
        #2;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_rd_out", 32'(rd_out), 32'd0);
        tick();
        tick();
        nrst = 1'b1;
        tick();

        // Directed table, each op issued from IDLE
        for (int i = 0; i < 21; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b,
                  5'(i + 1), vecs[i].exp, (i % 2) == 1);
            tick();
            chk($sformatf("vec%0d_done_pulse", i), 32'(done), 32'd0);
        end

        // Back-to-back: each op accepted in the previous op's DONE cycle
        do_op("b2b_a", 3'd0, 32'd3, 32'd5, 5'd4, 32'd15, 1'b0);
        do_op("b2b_b", 3'd5, 32'd1000, 32'd10, 5'd5, 32'd100, 1'b0);
        do_op("b2b_fast", 3'd5, 32'd1, 32'd0, 5'd6, 32'hFFFF_FFFF, 1'b0);
        do_op("b2b_c", 3'd7, 32'd1000, 32'd7, 5'd7, 32'd6, 1'b0);
        tick();

        // Flush at T10 of a DIV: IDLE at T11, no done, outputs held
        do_op("pre_flush", 3'd5, 32'd1000, 32'd3, 5'd9, 32'd333, 1'b0);
        tick();
        op = {1'b1, 3'd4};
        rs1 = 32'd1000;
        rs2 = 32'd7;
        rd_in = 5'd12;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        #1;
        chk("flush_t10_done", 32'(done), 32'd0);
        tick();
        flush = 1'b0;
        chk("flush_t11_busy", 32'(busy), 32'd0);
        chk("flush_t11_done", 32'(done), 32'd0);
        chk("flush_t11_result", result, 32'd333);
        chk("flush_t11_rd_out", 32'(rd_out), 32'd9);
        do_op("after_flush_mul", 3'd0, 32'd6, 32'd7, 5'd3, 32'd42, 1'b0);
        tick();

        // start together with flush, and start with op[3]=0, are ignored
        op = {1'b1, 3'd0};
        rs1 = 32'd6;
        rs2 = 32'd7;
        flush = 1'b1;
        start = 1'b1;
        #1;
        chk("collide_stall", 32'(stall), 32'd0);
        tick();
        start = 1'b0;
        flush = 1'b0;
        chk("collide_busy", 32'(busy), 32'd0);
        op = {1'b0, 3'd4};
        start = 1'b1;
        #1;
        chk("opinvalid_stall", 32'(stall), 32'd0);
        tick();
        start = 1'b0;
        chk("opinvalid_busy", 32'(busy), 32'd0);
        cnt_done = 0;
        repeat (40) begin
            if (done) cnt_done++;
            tick();
        end
        chk("ignored_no_done", 32'(cnt_done), 32'd0);
        chk("ignored_result_held", result, 32'd42);

        // Asynchronous reset at T20 of a MUL
        op = {1'b1, 3'd0};
        rs1 = 32'd1234;
        rs2 = 32'd5678;
        rd_in = 5'd17;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (19) tick();
        nrst = 1'b0;
        #1;
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_done", 32'(done), 32'd0);
        chk("midreset_stall", 32'(stall), 32'd0);
        chk("midreset_result", result, 32'd0);
        chk("midreset_rd_out", 32'(rd_out), 32'd0);
        tick();
        tick();
        nrst = 1'b1;
        cnt_done = 0;
        repeat (40) begin
            if (done) cnt_done++;
            tick();
        end
        chk("midreset_no_done", 32'(cnt_done), 32'd0);

        // Randomized operations against the reference model
        for (int k = 0; k < 150; k++) begin
            rf3 = 3'($urandom);
            ra = rand_opnd();
            rb = rand_opnd();
            rrd = 5'($urandom);
            do_op($sformatf("rand%0d_f%0d", k, rf3), rf3, ra, rb, rrd,
                  ref_model(rf3, ra, rb), (k % 3) == 0);
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
